remote_frame_decoder: RTL and testbench

Parametrised serial remote-control frame decoder: the next-generation key receiver for the front-panel/IR input path. It samples a demodulated serial line on a bit strobe, detects a start sequence, shifts in a configurable custom (address) field, key field and inverted-key field, validates the frame and presents the key with a `ready` strobe. Over the previous single-format receiver it adds width parameters, optional custom-code filtering, start-sequence timeout, an explicit frame error flag and auto-repeat detection.

---
 rtl/remote_frame_decoder.sv | 175 +++++++++++++++++
 tb/tb_remote_frame_decoder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/remote_frame_decoder.sv
// remote_frame_decoder: serial remote-control frame receiver with start sync, custom/key/inverted-key
// fields, optional custom filtering, sync timeout, frame error pulse and auto-repeat detection.
module remote_frame_decoder #(
    parameter int                  CUSTOM_W      = 16,
    parameter int                  KEY_W         = 8,
    parameter int                  CHECK_CUSTOM  = 0,
    parameter logic [CUSTOM_W-1:0] CUSTOM_ID     = '0,
    parameter int                  SYNC_MAX      = 16,
    parameter int                  READY_CYCLES  = 3,
    parameter int                  REPEAT_WINDOW = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                bit_en_i,
    input  logic                serial_i,
    output logic                ready_o,
    output logic [KEY_W-1:0]    remote_key_o,
    output logic [CUSTOM_W-1:0] custom_code_o,
    output logic                repeat_key_o,
    output logic                frame_error_o
);
    localparam int SW  = $clog2(SYNC_MAX + 1);
    localparam int RW  = $clog2(READY_CYCLES + 1);
    localparam int GW  = $clog2(REPEAT_WINDOW + 1);
    localparam int BW  = 6;

    typedef enum logic [2:0] {IDLE, SYNC, CUSTOM, KEY, INV, CHECK, VALID} state_t;

    state_t                state_q, state_d;
    logic [SW-1:0]         sync_q, sync_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [CUSTOM_W-1:0]   cust_sr_q, cust_sr_d;
    logic [KEY_W-1:0]      key_sr_q, key_sr_d;
    logic [KEY_W-1:0]      inv_sr_q, inv_sr_d;
    logic [RW-1:0]         rdy_cnt_q, rdy_cnt_d;
    logic                  ready_q, ready_d;
    logic [KEY_W-1:0]      remote_key_q, remote_key_d;
    logic [CUSTOM_W-1:0]   custom_code_q, custom_code_d;
    logic                  repeat_q, repeat_d;
    logic                  ferr_q, ferr_d;
    logic [KEY_W-1:0]      last_key_q, last_key_d;
    logic [CUSTOM_W-1:0]   last_cust_q, last_cust_d;
    logic                  hist_q, hist_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic                  frame_ok, is_rep;

    assign frame_ok = ((key_sr_q ^ inv_sr_q) == '1) && (CHECK_CUSTOM == 0 || cust_sr_q == CUSTOM_ID);
    assign is_rep   = hist_q && key_sr_q == last_key_q && cust_sr_q == last_cust_q
                      && gap_q < GW'(REPEAT_WINDOW);

    always_comb begin
        state_d       = state_q;
        sync_d        = sync_q;
        bit_d         = bit_q;
        cust_sr_d     = cust_sr_q;
        key_sr_d      = key_sr_q;
        inv_sr_d      = inv_sr_q;
        rdy_cnt_d     = rdy_cnt_q;
        ready_d       = ready_q;
        remote_key_d  = remote_key_q;
        custom_code_d = custom_code_q;
        repeat_d      = repeat_q;
        ferr_d        = 1'b0;
        last_key_d    = last_key_q;
        last_cust_d   = last_cust_q;
        hist_d        = hist_q;
        gap_d         = (gap_q == GW'(REPEAT_WINDOW)) ? gap_q : gap_q + 1'b1;
        case (state_q)
            IDLE: begin
                cust_sr_d = '0;
                key_sr_d  = '0;
                inv_sr_d  = '0;
                bit_d     = '0;
                if (bit_en_i && !serial_i) begin
                    state_d = SYNC;
                    sync_d  = SW'(1);
                end
            end
            SYNC: if (bit_en_i) begin
                if (serial_i) begin
                    state_d = CUSTOM;
                    bit_d   = '0;
                end else if (sync_q == SW'(SYNC_MAX - 1)) begin
                    state_d = IDLE;
                    ferr_d  = 1'b1;
                end else begin
                    sync_d = sync_q + 1'b1;
                end
            end
            CUSTOM: if (bit_en_i) begin
                cust_sr_d = CUSTOM_W'({cust_sr_q, serial_i});
                state_d   = (bit_q == BW'(CUSTOM_W - 1)) ? KEY : CUSTOM;
                bit_d     = (bit_q == BW'(CUSTOM_W - 1)) ? '0 : bit_q + 1'b1;
            end
            KEY: if (bit_en_i) begin
                key_sr_d = KEY_W'({key_sr_q, serial_i});
                state_d  = (bit_q == BW'(KEY_W - 1)) ? INV : KEY;
                bit_d    = (bit_q == BW'(KEY_W - 1)) ? '0 : bit_q + 1'b1;
            end
            INV: if (bit_en_i) begin
                inv_sr_d = KEY_W'({inv_sr_q, serial_i});
                state_d  = (bit_q == BW'(KEY_W - 1)) ? CHECK : INV;
                bit_d    = (bit_q == BW'(KEY_W - 1)) ? '0 : bit_q + 1'b1;
            end
            CHECK: if (frame_ok) begin
                state_d       = VALID;
                ready_d       = 1'b1;
                remote_key_d  = key_sr_q;
                custom_code_d = cust_sr_q;
                repeat_d      = is_rep;
                rdy_cnt_d     = '0;
                last_key_d    = key_sr_q;
                last_cust_d   = cust_sr_q;
                hist_d        = 1'b1;
                gap_d         = '0;
            end else begin
                state_d = IDLE;
                ferr_d  = 1'b1;
            end
            VALID: if (rdy_cnt_q == RW'(READY_CYCLES - 1)) begin
                state_d      = IDLE;
                ready_d      = 1'b0;
                remote_key_d = '1;
                repeat_d     = 1'b0;
            end else begin
                rdy_cnt_d = rdy_cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            sync_q        <= '0;
            bit_q         <= '0;
            cust_sr_q     <= '0;
            key_sr_q      <= '0;
            inv_sr_q      <= '0;
            rdy_cnt_q     <= '0;
            ready_q       <= 1'b0;
            remote_key_q  <= '1;
            custom_code_q <= '0;
            repeat_q      <= 1'b0;
            ferr_q        <= 1'b0;
            last_key_q    <= '0;
            last_cust_q   <= '0;
            hist_q        <= 1'b0;
            gap_q         <= '0;
        end else begin
            state_q       <= state_d;
            sync_q        <= sync_d;
            bit_q         <= bit_d;
            cust_sr_q     <= cust_sr_d;
            key_sr_q      <= key_sr_d;
            inv_sr_q      <= inv_sr_d;
            rdy_cnt_q     <= rdy_cnt_d;
            ready_q       <= ready_d;
            remote_key_q  <= remote_key_d;
            custom_code_q <= custom_code_d;
            repeat_q      <= repeat_d;
            ferr_q        <= ferr_d;
            last_key_q    <= last_key_d;
            last_cust_q   <= last_cust_d;
            hist_q        <= hist_d;
            gap_q         <= gap_d;
        end
    end

    assign ready_o       = ready_q;
    assign remote_key_o  = remote_key_q;
    assign custom_code_o = custom_code_q;
    assign repeat_key_o  = repeat_q;
    assign frame_error_o = ferr_q;
endmodule

// File: tb/tb_remote_frame_decoder.sv
// tb_remote_frame_decoder: directed frames against a default decoder and a custom-filtering one
// sharing the same serial line.
module tb_remote_frame_decoder;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        bit_en = 1'b0;
    logic        serial = 1'b1;
    logic        ready1, rep1, ferr1, ready2, rep2, ferr2;
    logic [7:0]  key1, key2;
    logic [15:0] cust1, cust2;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    remote_frame_decoder dut1 (
        .clk(clk), .reset(reset), .bit_en_i(bit_en), .serial_i(serial),
        .ready_o(ready1), .remote_key_o(key1), .custom_code_o(cust1),
        .repeat_key_o(rep1), .frame_error_o(ferr1)
    );

    remote_frame_decoder #(.CHECK_CUSTOM(1), .CUSTOM_ID(16'h00FF)) dut2 (
        .clk(clk), .reset(reset), .bit_en_i(bit_en), .serial_i(serial),
        .ready_o(ready2), .remote_key_o(key2), .custom_code_o(cust2),
        .repeat_key_o(rep2), .frame_error_o(ferr2)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, act, exp);
        end
    endtask

    task automatic strobe(input logic b, input int sp);
        repeat (sp - 1) begin
            @(negedge clk);
            bit_en = 1'b0;
            serial = ~b;
        end
        @(negedge clk);
        bit_en = 1'b1;
        serial = b;
    endtask

    task automatic send_frame(input logic [15:0] c, input logic [7:0] k, input logic [7:0] i,
                              input int lows, input int sp);
        logic [31:0] bits;
        bits = {c, k, i};
        repeat (lows) strobe(1'b0, sp);
        strobe(1'b1, sp);
        for (int n = 31; n >= 0; n--) strobe(bits[n], sp);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bit_en = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_frame(input string t, input logic [7:0] k, input logic [15:0] c,
                               input logic rep, input logic ok2);
        @(negedge clk);
        bit_en = 1'b0;
        chk({t, "_check_rdy"}, 32'(ready1), 32'd0);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk({t, "_rdy"}, 32'(ready1), 32'd1);
            chk({t, "_key"}, 32'(key1), 32'(k));
            chk({t, "_cust"}, 32'(cust1), 32'(c));
            chk({t, "_rep"}, 32'(rep1), 32'(rep));
            if (n == 0) begin
                chk({t, "_rdy2"}, 32'(ready2), 32'(ok2));
                chk({t, "_ferr2"}, 32'(ferr2), 32'(!ok2));
            end
        end
        @(negedge clk);
        chk({t, "_rdy_end"}, 32'(ready1), 32'd0);
        chk({t, "_key_end"}, 32'(key1), 32'hFF);
        chk({t, "_rep_end"}, 32'(rep1), 32'd0);
    endtask

    task automatic check_reject(input string t, input logic [15:0] c);
        @(negedge clk);
        bit_en = 1'b0;
        chk({t, "_ferr_pre"}, 32'(ferr1), 32'd0);
        @(negedge clk);
        chk({t, "_ferr"}, 32'(ferr1), 32'd1);
        chk({t, "_ferr2"}, 32'(ferr2), 32'd1);
        chk({t, "_rdy"}, 32'(ready1), 32'd0);
        chk({t, "_cust"}, 32'(cust1), 32'(c));
        @(negedge clk);
        chk({t, "_ferr_post"}, 32'(ferr1), 32'd0);
        chk({t, "_rdy_post"}, 32'(ready1), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ready1), 32'd0);
        chk("rst_key", 32'(key1), 32'hFF);
        chk("rst_cust", 32'(cust1), 32'd0);
        chk("rst_rep", 32'(rep1), 32'd0);
        chk("rst_ferr", 32'(ferr1), 32'd0);
        reset = 1'b1;
        idle(2);

        send_frame(16'h00FF, 8'h45, 8'hBA, 1, 1);
        check_frame("first", 8'h45, 16'h00FF, 1'b0, 1'b1);
        idle(100);
        send_frame(16'h00FF, 8'h45, 8'hBA, 1, 1);
        check_frame("repeat", 8'h45, 16'h00FF, 1'b1, 1'b1);
        idle(2000);
        send_frame(16'h00FF, 8'h45, 8'hBA, 1, 1);
        check_frame("late", 8'h45, 16'h00FF, 1'b0, 1'b1);

        idle(5);
        send_frame(16'h1234, 8'h45, 8'hBB, 1, 1);
        check_reject("badinv", 16'h00FF);
        idle(5);
        send_frame(16'h10EF, 8'h33, 8'hCC, 1, 1);
        check_frame("filter", 8'h33, 16'h10EF, 1'b0, 1'b0);
        idle(5);
        send_frame(16'h00FF, 8'h45, 8'hBA, 1, 1);
        check_frame("after_err", 8'h45, 16'h00FF, 1'b0, 1'b1);

        idle(5);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 15) chk("sync_pre", 32'(ferr1), 32'd0);
            bit_en = 1'b1;
            serial = 1'b0;
        end
        @(negedge clk);
        bit_en = 1'b0;
        chk("sync_ferr", 32'(ferr1), 32'd1);
        chk("sync_rdy", 32'(ready1), 32'd0);
        @(negedge clk);
        chk("sync_ferr_post", 32'(ferr1), 32'd0);

        idle(5);
        send_frame(16'h00FF, 8'h12, 8'hED, 15, 4);
        check_frame("slow", 8'h12, 16'h00FF, 1'b0, 1'b1);

        idle(5);
        strobe(1'b0, 1);
        strobe(1'b1, 1);
        for (int n = 15; n >= 0; n--) strobe(n < 8 ? 1'b1 : 1'b0, 1);
        for (int n = 0; n < 4; n++) strobe(1'b0, 1);
        @(negedge clk);
        reset = 1'b0;
        bit_en = 1'b0;
        #1;
        chk("mid_rst_cust", 32'(cust1), 32'd0);
        chk("mid_rst_key", 32'(key1), 32'hFF);
        chk("mid_rst_ready", 32'(ready1), 32'd0);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("mid_rst_ferr", 32'(ferr1), 32'd0);
        end
        reset = 1'b1;
        idle(2);
        chk("post_rst_ferr", 32'(ferr1), 32'd0);
        send_frame(16'h00FF, 8'h12, 8'hED, 1, 1);
        check_frame("post_rst", 8'h12, 16'h00FF, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
